uart_ctrl_rx: RTL and testbench
===============================

# uart_ctrl_rx

UART control receiver: deserialises 8N1 bytes from the host serial link and turns key codes into held paddle-direction levels and a one-cycle start pulse. It is the serial front end of the input path, sitting between the `uart_rx` pin and the input-selection logic that drives `pong_logic` and `start_menu`. It runs in the 50 MHz system clock domain.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 115200, line rate. `CPB = CLK_HZ/BAUD` (434 at defaults); `HALF = CPB/2` (217).
- `HOLD_MS`, 60, time a direction stays asserted after its last key byte. `HOLD_CLKS = HOLD_MS*CLK_HZ/1000`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous active-low reset.
- `uart_rx`  in  1  raw serial input, idle high, asynchronous to `clk`.
- `p1_up`, `p1_down`, `p2_up`, `p2_down`  out  1 each  held direction levels.
- `start_trigger`  out  1  one-cycle pulse on a start key.
- `rx_byte`  out  8  last good byte; holds its value between frames.
- `rx_valid`  out  1  one-cycle pulse when `rx_byte` updates.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped for a bad stop bit.

## Operation
- Input conditioning: `uart_rx` passes through a 2-FF synchroniser (both flops reset to 1) to give `rx_s`.
- Receive FSM states: IDLE, START, DATA, STOP.
  - IDLE: if `rx_s` = 0, clear the bit counter and go to START.
  - START: count `HALF` cycles, then sample. If `rx_s` = 1, treat it as a glitch and return to IDLE with no pulse. Otherwise go to DATA.
  - DATA: sample every `CPB` cycles, LSB first, 8 bits, then go to STOP.
  - STOP: sample after `CPB` cycles. If 1: load `rx_byte`, pulse `rx_valid`, decode, return to IDLE. If 0: pulse `frame_err`, leave `rx_byte` unchanged, do no decode, wait in STOP until `rx_s` = 1, then go to IDLE.
- Decode (ASCII, case-insensitive):
  - `w` (0x77/0x57) → P1 up.
  - `s` (0x73/0x53) → P1 down.
  - `i` (0x69/0x49) → P2 up.
  - `k` (0x6B/0x4B) → P2 down.
  - space (0x20) or CR (0x0D) → `start_trigger`.
  - Any other byte only pulses `rx_valid`.
- Direction hold:
  - Each player has one hold timer and one 2-bit direction register: none, up, or down.
  - A direction key sets that player's direction (the opposite direction clears immediately) and reloads the timer to `HOLD_CLKS`.
  - The timer decrements each cycle. When it reaches 0 the direction goes to none.
  - A repeat of the same key before expiry reloads the timer, so the output stays high without a gap.
  - Keys for one player never affect the other player.
  - `up` and `down` for one player are never both 1.
- Arithmetic: counter width is `$clog2(CPB)`. Timer width is `$clog2(HOLD_CLKS+1)`. All counts are unsigned and saturate at 0, with no wrap.

## Timing
- Reset values: all outputs 0; `rx_byte` = 0x00; FSM in IDLE; timers 0; synchroniser flops 1.
- Reset asserted mid-frame aborts the frame immediately with no pulse. After release the receiver waits for a fresh falling edge.
- Latency: `rx_valid`, `start_trigger` and direction-set all assert in the same cycle. That cycle is `HALF + 9*CPB` cycles (±1) after the first cycle `rx_s` = 0, plus 2 synchroniser cycles from the pin.
- Direction release: the output drops exactly `HOLD_CLKS` cycles after the cycle it was set or reloaded.
- Back-to-back frames: a start bit that immediately follows a valid stop bit is accepted, with no idle cycles needed.
- Simultaneous events: if a reload and an expiry fall in the same cycle, the reload wins.

## Structure
- Shared package `pong_input_pkg`:
  - key-code constants (`KEY_P1_UP`, …, `KEY_START`, `KEY_CR`);
  - direction encoding (`DIR_NONE`=0, `DIR_UP`=1, `DIR_DOWN`=2);
  - the `CPB`/`HALF` derivation function.
- Sub-module `uart_rx_core` (synchroniser + FSM → `rx_byte`/`rx_valid`/`frame_err`).
- The top-level block adds the decode logic and two instances of the hold logic.

## Test plan
- Default parameters, send 0x77 at 115200 → one `rx_valid` with `rx_byte` = 0x77; `p1_up` = 1 for exactly 3_000_000 cycles, then 0; P2 outputs stay 0 throughout.
- `HOLD_MS`=1 (50_000 cycles): send `s`, then `w` 20_000 cycles later → `p1_down` goes 1 → 0 and `p1_up` goes 0 → 1 in the same cycle; `p1_up` holds 50_000 cycles from the second byte.
- Send `W`, `i`, 0x20 back-to-back → `p1_up` = 1, `p2_up` = 1, one `start_trigger` pulse; 3 `rx_valid` pulses spaced 4340 cycles apart.
- Send 0x41 with stop bit forced 0 → `frame_err` pulse, no `rx_valid`, `rx_byte` unchanged; the next byte 0x6B is received correctly and `p2_down` = 1.
- Pulse `uart_rx` low for 100 cycles → no `rx_valid`, no `frame_err`, FSM back in IDLE.
- Assert `rst` during DATA of 0x73, release, then send 0x69 → the first byte produces nothing; the second gives `rx_byte` = 0x69 and `p2_up` = 1.

Source files
------------

// File: rtl/pong_input_pkg.sv
// Shared key codes, direction encoding and baud helpers
// for the serial paddle-input path.
package pong_input_pkg;

  localparam logic [7:0] KEY_P1_UP = 8'h77;
  localparam logic [7:0] KEY_P1_DN = 8'h73;
  localparam logic [7:0] KEY_P2_UP = 8'h69;
  localparam logic [7:0] KEY_P2_DN = 8'h6B;
  localparam logic [7:0] KEY_START = 8'h20;
  localparam logic [7:0] KEY_CR    = 8'h0D;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic int calc_cpb(int clk_hz, int baud);
    return clk_hz / baud;
  endfunction

  function automatic int calc_half(int cpb);
    return cpb / 2;
  endfunction

  // Lower-case letter key or its upper-case twin (bit 5 clear).
  function automatic logic is_key(logic [7:0] b, logic [7:0] lc);
    return (b == lc) || (b == (lc & 8'hDF));
  endfunction

endpackage

// File: rtl/dir_hold.sv
// Per-player direction register with a retriggerable hold timer.
// A key reload beats the expiry that would land in the same cycle.
module dir_hold
  import pong_input_pkg::*;
#(
  parameter int HOLD_CLKS = 3_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_up,
  input  logic key_dn,
  output logic up,
  output logic down
);

  localparam int TW = $clog2(HOLD_CLKS + 1);

  dir_t          dir, dir_d;
  logic [TW-1:0] tmr, tmr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir <= DIR_NONE;
      tmr <= '0;
    end else begin
      dir <= dir_d;
      tmr <= tmr_d;
    end
  end

  always_comb begin
    dir_d = dir;
    tmr_d = tmr;
    unique case (1'b1)
      key_up: begin
        dir_d = DIR_UP;
        tmr_d = TW'(HOLD_CLKS);
      end
      key_dn: begin
        dir_d = DIR_DOWN;
        tmr_d = TW'(HOLD_CLKS);
      end
      default: begin
        if (tmr > TW'(1)) begin
          tmr_d = tmr - 1'b1;
        end else begin
          tmr_d = '0;
          dir_d = DIR_NONE;
        end
      end
    endcase
  end

  assign up   = (dir == DIR_UP);
  assign down = (dir == DIR_DOWN);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-FF synchroniser plus start/data/stop FSM.
// byte_stb/byte_nxt announce a good byte one edge before rx_valid.
module uart_rx_core
  import pong_input_pkg::*;
#(
  parameter int CPB  = 434,
  parameter int HALF = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       byte_stb,
  output logic [7:0] byte_nxt
);

  localparam int CW = $clog2(CPB);

  logic            sync1, rx_s;
  rx_state_t       state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      bit_idx, bit_d;
  logic [7:0]      sh, sh_d;
  logic            err_wait, err_d;
  logic            ferr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      err_wait  <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_d;
      sh        <= sh_d;
      err_wait  <= err_d;
      rx_valid  <= byte_stb;
      frame_err <= ferr_d;
      if (byte_stb) rx_byte <= sh;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    bit_d    = bit_idx;
    sh_d     = sh;
    err_d    = err_wait;
    byte_stb = 1'b0;
    ferr_d   = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh[7:1]};
          if (bit_idx == 3'd7) state_d = RX_STOP;
          else                 bit_d   = bit_idx + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        // After a bad stop bit, hold off until the line returns high.
        if (err_wait) begin
          if (rx_s) begin
            err_d   = 1'b0;
            state_d = RX_IDLE;
          end
        end else if (cnt == CW'(CPB - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_stb = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            ferr_d = 1'b1;
            err_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_nxt = sh;

endmodule

// File: rtl/uart_ctrl_rx.sv
// Serial key receiver: decodes paddle keys into held levels
// and space/CR into a one-cycle start pulse.
module uart_ctrl_rx
  import pong_input_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 115200,
  parameter int HOLD_MS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       start_trigger,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CPB  = calc_cpb(CLK_HZ, BAUD);
  localparam int HALF = calc_half(CPB);
  localparam longint HOLD_L =
    longint'(HOLD_MS) * longint'(CLK_HZ) / longint'(1000);
  localparam int HOLD_CLKS = int'(HOLD_L);

  logic       stb;
  logic [7:0] nxt;
  logic       k1u, k1d, k2u, k2d, kst;

  uart_rx_core #(
    .CPB  (CPB),
    .HALF (HALF)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .byte_stb  (stb),
    .byte_nxt  (nxt)
  );

  assign k1u = stb && is_key(nxt, KEY_P1_UP);
  assign k1d = stb && is_key(nxt, KEY_P1_DN);
  assign k2u = stb && is_key(nxt, KEY_P2_UP);
  assign k2d = stb && is_key(nxt, KEY_P2_DN);
  assign kst = stb && (nxt == KEY_START || nxt == KEY_CR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) start_trigger <= 1'b0;
    else      start_trigger <= kst;
  end

  dir_hold #(.HOLD_CLKS(HOLD_CLKS)) u_p1 (
    .clk    (clk),
    .rst    (rst),
    .key_up (k1u),
    .key_dn (k1d),
    .up     (p1_up),
    .down   (p1_down)
  );

  dir_hold #(.HOLD_CLKS(HOLD_CLKS)) u_p2 (
    .clk    (clk),
    .rst    (rst),
    .key_up (k2u),
    .key_dn (k2d),
    .up     (p2_up),
    .down   (p2_down)
  );

endmodule

// File: tb/tb_uart_ctrl_rx.sv
// Directed bench for uart_ctrl_rx at a scaled-down clock:
// 16 clocks per bit, 1600-cycle hold.
module tb_uart_ctrl_rx;

  localparam int CLK_HZ  = 160_000;
  localparam int BAUD    = 10_000;
  localparam int HOLD_MS = 10;
  localparam int CPB     = 16;
  localparam int HALF    = 8;
  localparam int HOLD    = 1600;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rx = 1'b1;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic       start_trigger, rx_valid, frame_err;
  logic [7:0] rx_byte;

  int n_chk = 0;
  int n_err = 0;

  int cyc = 0;
  int t_sof = 0;
  int nvalid = 0, nferr = 0, nstart = 0, nboth = 0, np2 = 0;
  int vt [64];
  int p1u_rise = 0, p1u_fall = 0, p1d_fall = 0;
  logic p1u_q = 1'b0, p1d_q = 1'b0;

  uart_ctrl_rx #(
    .CLK_HZ  (CLK_HZ),
    .BAUD    (BAUD),
    .HOLD_MS (HOLD_MS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .p1_up         (p1_up),
    .p1_down       (p1_down),
    .p2_up         (p2_up),
    .p2_down       (p2_down),
    .start_trigger (start_trigger),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      vt[nvalid % 64] <= cyc;
      nvalid <= nvalid + 1;
    end
    if (frame_err) nferr <= nferr + 1;
    if (start_trigger) nstart <= nstart + 1;
    if ((p1_up && p1_down) || (p2_up && p2_down)) nboth <= nboth + 1;
    if (p2_up || p2_down) np2 <= np2 + 1;
    if (p1_up && !p1u_q) p1u_rise <= cyc;
    if (!p1_up && p1u_q) p1u_fall <= cyc;
    if (!p1_down && p1d_q) p1d_fall <= cyc;
    p1u_q <= p1_up;
    p1d_q <= p1_down;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    uart_rx = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    t_sof = cyc;
    uart_rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic wait_p1u_low(input string tag);
    for (int i = 0; i < HOLD + 400 && p1_up; i++) @(negedge clk);
    check(tag, {31'd0, p1_up}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int nv0, nf0, ns0, iw, iw2, lat;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_byte", {24'd0, rx_byte}, 32'h00);
    check("rst_outs", {25'd0, p1_up, p1_down, p2_up, p2_down,
          start_trigger, rx_valid, frame_err}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 'w': one valid, p1_up held exactly HOLD cycles
    send_byte(8'h77, 1'b1);
    check("t1_nvalid", nvalid, 1);
    check("t1_byte", {24'd0, rx_byte}, 32'h77);
    check("t1_p1up", {31'd0, p1_up}, 32'd1);
    lat = vt[0] - t_sof;
    check("t1_latency", {31'd0, (lat >= HALF + 9*CPB + 1) &&
          (lat <= HALF + 9*CPB + 4)}, 32'd1);
    check("t1_set_cycle", p1u_rise, vt[0]);
    wait_p1u_low("t1_release_timeout");
    check("t1_hold_len", p1u_fall - p1u_rise, HOLD);
    check("t1_p2_quiet", np2, 0);

    // 's' then 'w': direction swaps in one cycle, reload without gap
    send_byte(8'h73, 1'b1);
    check("t2_p1down", {31'd0, p1_down}, 32'd1);
    check("t2_p1up_off", {31'd0, p1_up}, 32'd0);
    repeat (400) @(negedge clk);
    send_byte(8'h77, 1'b1);
    iw = (nvalid - 1) % 64;
    check("t2_p1up", {31'd0, p1_up}, 32'd1);
    check("t2_p1down_off", {31'd0, p1_down}, 32'd0);
    check("t2_swap_same_cycle", p1d_fall, p1u_rise);
    repeat (200) @(negedge clk);
    send_byte(8'h77, 1'b1);
    iw2 = (nvalid - 1) % 64;
    wait_p1u_low("t2_release_timeout");
    check("t2_no_gap", p1u_rise, vt[iw]);
    check("t2_reload_hold", p1u_fall - vt[iw2], HOLD);

    // 'W', 'i', space back to back
    nv0 = nvalid;
    ns0 = nstart;
    send_byte(8'h57, 1'b1);
    send_byte(8'h69, 1'b1);
    send_byte(8'h20, 1'b1);
    @(negedge clk);
    check("t3_nvalid", nvalid - nv0, 3);
    check("t3_gap1", vt[(nv0+1)%64] - vt[nv0%64], 10*CPB);
    check("t3_gap2", vt[(nv0+2)%64] - vt[(nv0+1)%64], 10*CPB);
    check("t3_p1up", {31'd0, p1_up}, 32'd1);
    check("t3_p2up", {31'd0, p2_up}, 32'd1);
    check("t3_start", nstart - ns0, 1);
    check("t3_byte", {24'd0, rx_byte}, 32'h20);
    repeat (HOLD + 50) @(negedge clk);

    // Bad stop bit, then a good 'k'
    nv0 = nvalid;
    nf0 = nferr;
    send_byte(8'h41, 1'b0);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("t4_ferr", nferr - nf0, 1);
    check("t4_novalid", nvalid - nv0, 0);
    check("t4_byte_kept", {24'd0, rx_byte}, 32'h20);
    send_byte(8'h6B, 1'b1);
    check("t4_byte", {24'd0, rx_byte}, 32'h6B);
    check("t4_p2down", {31'd0, p2_down}, 32'd1);

    // Short low glitch is ignored; next frame still lands
    nv0 = nvalid;
    nf0 = nferr;
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3*CPB) @(negedge clk);
    check("t5_novalid", nvalid - nv0, 0);
    check("t5_noferr", nferr - nf0, 0);
    send_byte(8'h55, 1'b1);
    check("t5_after_glitch", {24'd0, rx_byte}, 32'h55);

    // Reset during DATA of 's', then 'i'
    nv0 = nvalid;
    nf0 = nferr;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(i < 2);
    @(negedge clk);
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_byte", {24'd0, rx_byte}, 32'h00);
    check("t6_rst_outs", {25'd0, p1_up, p1_down, p2_up, p2_down,
          start_trigger, rx_valid, frame_err}, 32'd0);
    rst = 1'b1;
    repeat (12*CPB) @(negedge clk);
    check("t6_novalid", nvalid - nv0, 0);
    check("t6_noferr", nferr - nf0, 0);
    check("t6_p1down_off", {31'd0, p1_down}, 32'd0);
    send_byte(8'h69, 1'b1);
    check("t6_byte", {24'd0, rx_byte}, 32'h69);
    check("t6_p2up", {31'd0, p2_up}, 32'd1);

    check("never_both_dirs", nboth, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
